tohost_status_monitor: RTL

//   Sits inside the test harness, between the chip's tohost write channel and the simulation top's success/failure check.

---
 rtl/tohost_mon_pkg.sv | 20 ++
 rtl/tohost_mon_fifo.sv | 55 +++++
 rtl/tohost_status_monitor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tohost_mon_pkg.sv
// rtl/tohost_mon_pkg.sv - shared types and constants for the tohost status monitor
package tohost_mon_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        R_NONE    = 2'd0,
        R_EXIT    = 2'd1,
        R_TIMEOUT = 2'd2,
        R_STALL   = 2'd3
    } reason_e;

    localparam int unsigned TOHOST_EXIT_BIT = 0;
    localparam int unsigned CON_BYTE_W      = 8;

endpackage

// File: rtl/tohost_mon_fifo.sv
// rtl/tohost_mon_fifo.sv - synchronous console byte FIFO, wrap-bit pointers
module tohost_mon_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             core_clock,
    input  logic             reset,
    input  logic             push_valid_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    output logic             empty_o,
    input  logic             pop_ready_i,
    output logic             pop_valid_o,
    output logic [WIDTH-1:0] pop_data_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push     = push_valid_i && !full_o;
    assign do_pop      = pop_ready_i && !empty_o;
    assign pop_valid_o = !empty_o;
    assign pop_data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge core_clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge core_clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/tohost_status_monitor.sv
// rtl/tohost_status_monitor.sv - tohost decode, console FIFO, watchdog and sticky verdict (stall watchdog: TOHOST_MON_STALL_EN)
module tohost_status_monitor
    import tohost_mon_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CODE_W       = 32,
    parameter int unsigned STALL_CYCLES = 1000000
) (
    input  logic              core_clock,
    input  logic              reset,
    input  logic              tohost_valid,
    output logic              tohost_ready,
    input  logic [63:0]       tohost_data,
    input  logic [63:0]       max_cycles,
    output logic              con_valid,
    input  logic              con_ready,
    output logic [7:0]        con_data,
    output logic              success,
    output logic              failure,
    output logic [CODE_W-1:0] exit_code,
    output logic [1:0]        reason,
    output logic [63:0]       cycle_count
);

    state_e              state_q, state_d;
    reason_e             reason_q, reason_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [63:0]         count_q, count_d;

    logic                fifo_full, fifo_empty;
    logic                is_exit, in_run, accept, push;
    logic                timeout_hit, stall_hit;
    logic [CODE_W-1:0]   word_code;
    logic                unused_data_bits;

    assign unused_data_bits = ^tohost_data;

    assign is_exit   = tohost_data[TOHOST_EXIT_BIT];
    assign word_code = tohost_data[CODE_W:1];
    assign in_run    = (state_q == RUN);

    // Exit waits for an empty console path so every byte is printed before the verdict.
    assign tohost_ready = reset && in_run &&
                          (is_exit ? (fifo_empty && !con_valid) : !fifo_full);
    assign accept = tohost_valid && tohost_ready;
    assign push   = accept && !is_exit;

    assign timeout_hit = (max_cycles != 64'd0) && (count_q == max_cycles);

    tohost_mon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CON_BYTE_W)
    ) u_fifo (
        .core_clock   (core_clock),
        .reset        (reset),
        .push_valid_i (push),
        .push_data_i  (tohost_data[CON_BYTE_W-1:0]),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .pop_ready_i  (con_ready),
        .pop_valid_o  (con_valid),
        .pop_data_o   (con_data)
    );

`ifdef TOHOST_MON_STALL_EN
    logic [31:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (in_run) idle_d = accept ? 32'd0 : idle_q + 32'd1;
    end

    always_ff @(posedge core_clock) begin
        if (!reset) idle_q <= 32'd0;
        else        idle_q <= idle_d;
    end

    assign stall_hit = !accept && (idle_q == 32'(STALL_CYCLES));
`else
    localparam int unsigned unused_stall_cycles = STALL_CYCLES;
    assign stall_hit = 1'b0;
`endif

    // Priority: exit handshake, then timeout, then stall.
    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        code_d   = code_q;
        if (in_run) begin
            if (accept && is_exit) begin
                if (word_code == '0) begin
                    state_d = PASS;
                end else begin
                    state_d  = FAIL;
                    reason_d = R_EXIT;
                    code_d   = word_code;
                end
            end else if (timeout_hit) begin
                state_d  = FAIL;
                reason_d = R_TIMEOUT;
            end else if (stall_hit) begin
                state_d  = FAIL;
                reason_d = R_STALL;
            end
        end
    end

    // The cycle that leaves RUN does not count, so a timeout freezes at max_cycles.
    always_comb begin
        count_d = count_q;
        if (in_run && (state_d == RUN) && (count_q != '1)) count_d = count_q + 64'd1;
    end

    always_ff @(posedge core_clock) begin
        if (!reset) begin
            state_q  <= RUN;
            reason_q <= R_NONE;
            code_q   <= '0;
            count_q  <= 64'd0;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
            code_q   <= code_d;
            count_q  <= count_d;
        end
    end

    assign success     = (state_q == PASS);
    assign failure     = (state_q == FAIL);
    assign exit_code   = code_q;
    assign reason      = reason_q;
    assign cycle_count = count_q;

endmodule
